// File: rtl/stage_id_pipe_pkg.sv
// Shared decode types and helpers for the ID stage.
// Holds the control bundle handed to EX plus the decode/immediate functions.
package rvcpu;

    typedef logic [4:0] reg_t;

    localparam reg_t REG_ZERO = 5'd0;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_LUI
    } aluop_t;

    typedef enum logic [3:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } immtype_t;

    typedef struct packed {
        reg_t        rd;
        logic        rd_valid;
        aluop_t      aluop;
        logic        vld_decode;
        logic        is_branch;
        logic        is_jal;
        logic        is_wfi;
        logic [31:0] pc;
    } id_ctl_t;

    typedef struct packed {
        logic     rs1_valid;
        logic     rs2_valid;
        logic     rd_valid;
        aluop_t   aluop;
        immtype_t immtype;
        logic     is_branch;
        logic     is_jal;
        logic     is_wfi;
        logic     vld;
    } dec_t;

    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [31:0] INS_WFI   = 32'h10500073;

    function automatic aluop_t alu_f3(logic [2:0] f3, logic alt);
        aluop_t op;
        unique case (f3)
            3'd0:    op = alt ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = alt ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic dec_t decode(logic [31:0] ins);
        dec_t d;
        d = '0;
        d.aluop = ALU_ADD;
        d.immtype = IMM_NONE;
        unique case (ins[6:0])
            OPC_OPIMM: begin
                d = '{1'b1, 1'b0, 1'b1,
                      alu_f3(ins[14:12], ins[14:12] == 3'd5 && ins[30]),
                      IMM_I, 1'b0, 1'b0, 1'b0, 1'b1};
            end
            OPC_OP: begin
                d = '{1'b1, 1'b1, 1'b1, alu_f3(ins[14:12], ins[30]),
                      IMM_NONE, 1'b0, 1'b0, 1'b0, 1'b1};
            end
            OPC_LOAD, OPC_JALR: begin
                d = '{1'b1, 1'b0, 1'b1, ALU_ADD, IMM_I,
                      1'b0, 1'b0, 1'b0, 1'b1};
            end
            OPC_STORE: begin
                d = '{1'b1, 1'b0, 1'b0, ALU_ADD, IMM_S,
                      1'b0, 1'b0, 1'b0, 1'b1};
            end
            OPC_BRANCH: begin
                d = '{1'b1, 1'b1, 1'b0, ALU_SUB, IMM_B,
                      1'b1, 1'b0, 1'b0, 1'b1};
            end
            OPC_JAL: begin
                d = '{1'b0, 1'b0, 1'b1, ALU_ADD, IMM_J,
                      1'b0, 1'b1, 1'b0, 1'b1};
            end
            OPC_LUI: begin
                d = '{1'b0, 1'b0, 1'b1, ALU_LUI, IMM_U,
                      1'b0, 1'b0, 1'b0, 1'b1};
            end
            OPC_AUIPC: begin
                d = '{1'b0, 1'b0, 1'b1, ALU_ADD, IMM_U,
                      1'b0, 1'b0, 1'b0, 1'b1};
            end
            OPC_SYSTEM: begin
                d.is_wfi = (ins == INS_WFI);
                d.vld    = (ins == INS_WFI);
            end
            default: ;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] gen_imm(logic [31:7] i, immtype_t t);
        logic [31:0] v;
        unique case (t)
            IMM_I:   v = {{20{i[31]}}, i[31:20]};
            IMM_S:   v = {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   v = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_U:   v = {i[31:12], 12'b0};
            IMM_J:   v = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/stage_id_pipe_if.sv
// IF->ID and ID->EX valid/ready handshake bundle.
// slave is the ID stage view; master is the surrounding pipeline view.
interface stage_id_pipe_if #(
    parameter int Width = 32
);
    import rvcpu::*;

    logic             in_valid;
    logic             in_ready;
    logic [Width-1:0] in_pc;
    logic [31:0]      in_opcode;
    logic             out_valid;
    logic             out_ready;
    logic [Width-1:0] out_a;
    logic [Width-1:0] out_b;
    id_ctl_t          out_ctl;

    modport master (
        output in_valid, in_pc, in_opcode, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_ctl
    );

    modport slave (
        input  in_valid, in_pc, in_opcode, out_ready,
        output in_ready, out_valid, out_a, out_b, out_ctl
    );

endinterface

// File: rtl/stage_id_pipe_bypass.sv
// Operand forwarding for one source register.
// Lowest-index matching source wins; x0 always reads the regfile.
module id_bypass
    import rvcpu::*;
#(
    parameter int Width     = 32,
    parameter int NumBypass = 2
) (
    input  reg_t                       addr_i,
    input  logic [Width-1:0]           rf_data_i,
    input  logic [NumBypass-1:0]       byp_valid_i,
    input  logic [NumBypass*5-1:0]     byp_rd_i,
    input  logic [NumBypass*Width-1:0] byp_data_i,
    output logic [Width-1:0]           data_o
);

    // Scan oldest to youngest so the youngest match overrides.
    always_comb begin
        data_o = rf_data_i;
        for (int i = NumBypass - 1; i >= 0; i--) begin
            if (addr_i != REG_ZERO && byp_valid_i[i] &&
                byp_rd_i[i*5 +: 5] == addr_i) begin
                data_o = byp_data_i[i*Width +: Width];
            end
        end
    end

endmodule

// File: rtl/stage_id_pipe.sv
// Registered decode stage: decode, forward, hazard check, one-entry
// output register towards EX with flush and a saturating stall counter.
module stage_id_pipe
    import rvcpu::*;
#(
    parameter int Width     = 32,
    parameter int NumBypass = 2,
    parameter int CntWidth  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    stage_id_pipe_if.slave             pipe,
    output reg_t                       rs1,
    output reg_t                       rs2,
    input  logic [Width-1:0]           rs1_data,
    input  logic [Width-1:0]           rs2_data,
    input  logic [NumBypass-1:0]       byp_valid,
    input  logic [NumBypass*5-1:0]     byp_rd,
    input  logic [NumBypass*Width-1:0] byp_data,
    input  logic                       ld_pending,
    input  reg_t                       ld_rd,
    input  logic                       flush,
    output logic [CntWidth-1:0]        stall_cnt
);

    dec_t             dec;
    logic [31:0]      imm;
    logic [Width-1:0] fwd1, fwd2;
    logic [Width-1:0] a_d, b_d, a_q, b_q;
    id_ctl_t          ctl_d, ctl_q;
    logic             valid_d, valid_q;
    logic [CntWidth-1:0] cnt_d, cnt_q;
    logic             hazard, in_ready, take;

    assign rs1 = pipe.in_opcode[19:15];
    assign rs2 = pipe.in_opcode[24:20];
    assign dec = decode(pipe.in_opcode);
    assign imm = gen_imm(pipe.in_opcode[31:7], dec.immtype);

    id_bypass #(.Width(Width), .NumBypass(NumBypass)) u_byp1 (
        .addr_i(rs1), .rf_data_i(rs1_data), .byp_valid_i(byp_valid),
        .byp_rd_i(byp_rd), .byp_data_i(byp_data), .data_o(fwd1)
    );

    id_bypass #(.Width(Width), .NumBypass(NumBypass)) u_byp2 (
        .addr_i(rs2), .rf_data_i(rs2_data), .byp_valid_i(byp_valid),
        .byp_rd_i(byp_rd), .byp_data_i(byp_data), .data_o(fwd2)
    );

    assign hazard = pipe.in_valid && ld_pending && ld_rd != REG_ZERO &&
                    ((dec.rs1_valid && rs1 == ld_rd) ||
                     (dec.rs2_valid && rs2 == ld_rd));

    // A flush drops whatever IF presents, so it is always accepted.
    assign in_ready = flush ? 1'b1 : (!hazard && (!valid_q || pipe.out_ready));
    assign take     = !flush && pipe.in_valid && in_ready;

    // Operand select, control bundle and next-state for valid/counter.
    always_comb begin
        a_d = dec.rs1_valid ? fwd1 : pipe.in_pc;
        b_d = dec.rs2_valid ? fwd2 : Width'(imm);
        ctl_d = '0;
        ctl_d.rd         = pipe.in_opcode[11:7];
        ctl_d.rd_valid   = dec.rd_valid;
        ctl_d.aluop      = dec.aluop;
        ctl_d.vld_decode = dec.vld;
        ctl_d.is_branch  = dec.is_branch;
        ctl_d.is_jal     = dec.is_jal;
        ctl_d.is_wfi     = dec.is_wfi;
        ctl_d.pc         = 32'(pipe.in_pc);
        valid_d = valid_q;
        if (flush)               valid_d = 1'b0;
        else if (take)           valid_d = 1'b1;
        else if (pipe.out_ready) valid_d = 1'b0;
        cnt_d = cnt_q;
        if (hazard && !flush && cnt_q != '1) cnt_d = cnt_q + CntWidth'(1);
    end

    // Pipeline register: bundle only loads on acceptance, so a held
    // bundle keeps the operands it was captured with.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            ctl_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            if (take) begin
                a_q   <= a_d;
                b_q   <= b_d;
                ctl_q <= ctl_d;
            end
        end
    end

    assign pipe.in_ready  = in_ready;
    assign pipe.out_valid = valid_q;
    assign pipe.out_a     = a_q;
    assign pipe.out_b     = b_q;
    assign pipe.out_ctl   = ctl_q;
    assign stall_cnt      = cnt_q;

endmodule

// File: tb/tb_stage_id_pipe.sv
// Directed bench for stage_id_pipe; a second copy with a 4-bit
// stall counter shares the stimulus to exercise saturation.
module tb_stage_id_pipe;
    import rvcpu::*;

    localparam logic [31:0] ADDI = 32'h00708293;
    localparam logic [31:0] ADD  = 32'h002081B3;
    localparam logic [31:0] ADD0 = 32'h000001B3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    reg_t        rs1, rs2, rs1_4, rs2_4;
    logic [31:0] rs1_data, rs2_data;
    logic [1:0]  byp_valid;
    logic [9:0]  byp_rd;
    logic [63:0] byp_data;
    logic        ld_pending, flush;
    reg_t        ld_rd;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
    int          n_vec = 0;
    int          n_bad = 0;

    stage_id_pipe_if #(.Width(32)) p ();
    stage_id_pipe_if #(.Width(32)) p4 ();

    assign p4.in_valid  = p.in_valid;
    assign p4.in_pc     = p.in_pc;
    assign p4.in_opcode = p.in_opcode;
    assign p4.out_ready = p.out_ready;

    stage_id_pipe #(.Width(32), .NumBypass(2), .CntWidth(16)) dut (
        .clk(clk), .rst(rst), .pipe(p.slave),
        .rs1(rs1), .rs2(rs2), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .byp_valid(byp_valid), .byp_rd(byp_rd), .byp_data(byp_data),
        .ld_pending(ld_pending), .ld_rd(ld_rd), .flush(flush),
        .stall_cnt(cnt)
    );

    stage_id_pipe #(.Width(32), .NumBypass(2), .CntWidth(4)) dut4 (
        .clk(clk), .rst(rst), .pipe(p4.slave),
        .rs1(rs1_4), .rs2(rs2_4), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .byp_valid(byp_valid), .byp_rd(byp_rd), .byp_data(byp_data),
        .ld_pending(ld_pending), .ld_rd(ld_rd), .flush(flush),
        .stall_cnt(cnt4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        p.in_valid = 1'b0;
        p.in_pc = '0;
        p.in_opcode = '0;
        p.out_ready = 1'b1;
        rs1_data = '0;
        rs2_data = '0;
        byp_valid = '0;
        byp_rd = '0;
        byp_data = '0;
        ld_pending = 1'b0;
        ld_rd = '0;
        flush = 1'b0;
        tick();
        tick();
        chk("rst_valid", 64'(p.out_valid), 64'd0);
        chk("rst_a", 64'(p.out_a), 64'd0);
        chk("rst_b", 64'(p.out_b), 64'd0);
        chk("rst_rd", 64'(p.out_ctl.rd), 64'd0);
        chk("rst_pc", 64'(p.out_ctl.pc), 64'd0);
        chk("rst_cnt", 64'(cnt), 64'd0);
        rst = 1'b1;
        tick();
        chk("hold_valid", 64'(p.out_valid), 64'd0);

        // addi x5,x1,7
        p.in_valid = 1'b1;
        p.in_pc = 32'h100;
        p.in_opcode = ADDI;
        rs1_data = 32'd10;
        #1;
        chk("addi_rdy", 64'(p.in_ready), 64'd1);
        chk("addi_rs1", 64'(rs1), 64'd1);
        tick();
        chk("addi_valid", 64'(p.out_valid), 64'd1);
        chk("addi_a", 64'(p.out_a), 64'd10);
        chk("addi_b", 64'(p.out_b), 64'd7);
        chk("addi_rd", 64'(p.out_ctl.rd), 64'd5);
        chk("addi_rdv", 64'(p.out_ctl.rd_valid), 64'd1);
        chk("addi_pc", 64'(p.out_ctl.pc), 64'h100);
        chk("addi_op", 64'(p.out_ctl.aluop), 64'(ALU_ADD));

        // add x3,x1,x2 with forwarding
        p.in_opcode = ADD;
        p.in_pc = 32'h104;
        rs1_data = 32'h11;
        rs2_data = 32'd4;
        byp_valid = 2'b11;
        byp_rd = {5'd1, 5'd1};
        byp_data = {32'hBB, 32'hAA};
        #1;
        chk("add_rs2", 64'(rs2), 64'd2);
        tick();
        chk("fwd_pri_a", 64'(p.out_a), 64'hAA);
        chk("fwd_pri_b", 64'(p.out_b), 64'd4);
        byp_valid = 2'b10;
        tick();
        chk("fwd_b1_a", 64'(p.out_a), 64'hBB);
        byp_valid = 2'b11;
        byp_rd = {5'd2, 5'd1};
        tick();
        chk("fwd_both_a", 64'(p.out_a), 64'hAA);
        chk("fwd_both_b", 64'(p.out_b), 64'hBB);
        byp_rd = {5'd0, 5'd0};
        p.in_opcode = ADD0;
        tick();
        chk("x0_a", 64'(p.out_a), 64'h11);
        chk("x0_b", 64'(p.out_b), 64'd4);

        // load-use stall on x2
        byp_valid = 2'b00;
        p.in_opcode = ADD;
        ld_pending = 1'b1;
        ld_rd = 5'd2;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ld_rdy", 64'(p.in_ready), 64'd0);
            tick();
            chk("ld_valid", 64'(p.out_valid), 64'd0);
        end
        chk("ld_cnt", 64'(cnt), 64'd3);
        ld_pending = 1'b0;
        rs1_data = 32'd1;
        rs2_data = 32'd2;
        #1;
        chk("ld_go_rdy", 64'(p.in_ready), 64'd1);
        tick();
        chk("ld_go_valid", 64'(p.out_valid), 64'd1);
        chk("ld_go_a", 64'(p.out_a), 64'd1);
        chk("ld_go_b", 64'(p.out_b), 64'd2);
        chk("ld_go_cnt", 64'(cnt), 64'd3);

        // backpressure: held bundle must not change
        p.out_ready = 1'b0;
        p.in_opcode = ADDI;
        rs1_data = 32'd99;
        byp_valid = 2'b01;
        byp_rd = {5'd0, 5'd1};
        byp_data = {32'h0, 32'h55};
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_rdy", 64'(p.in_ready), 64'd0);
            tick();
            chk("bp_valid", 64'(p.out_valid), 64'd1);
            chk("bp_a", 64'(p.out_a), 64'd1);
            chk("bp_b", 64'(p.out_b), 64'd2);
            chk("bp_rd", 64'(p.out_ctl.rd), 64'd3);
        end
        byp_valid = 2'b00;
        p.out_ready = 1'b1;
        #1;
        chk("b2b_rdy", 64'(p.in_ready), 64'd1);
        tick();
        chk("b2b_valid", 64'(p.out_valid), 64'd1);
        chk("b2b_a", 64'(p.out_a), 64'd99);
        chk("b2b_b", 64'(p.out_b), 64'd7);
        chk("b2b_rd", 64'(p.out_ctl.rd), 64'd5);
        p.in_valid = 1'b0;
        tick();
        chk("drain_valid", 64'(p.out_valid), 64'd0);

        // flush beats a hazard and a held bundle
        p.in_valid = 1'b1;
        rs1_data = 32'd5;
        tick();
        chk("pre_fl_a", 64'(p.out_a), 64'd5);
        p.out_ready = 1'b0;
        p.in_opcode = ADD;
        ld_pending = 1'b1;
        flush = 1'b1;
        #1;
        chk("fl_rdy", 64'(p.in_ready), 64'd1);
        tick();
        chk("fl_valid", 64'(p.out_valid), 64'd0);
        chk("fl_cnt", 64'(cnt), 64'd3);
        chk("fl_a", 64'(p.out_a), 64'd5);
        flush = 1'b0;

        // async reset in the middle of a stall
        ld_pending = 1'b0;
        p.in_opcode = ADDI;
        rs1_data = 32'd6;
        tick();
        chk("pre_rst_a", 64'(p.out_a), 64'd6);
        p.in_opcode = ADD;
        ld_pending = 1'b1;
        tick();
        chk("pre_rst_cnt", 64'(cnt), 64'd4);
        chk("pre_rst_valid", 64'(p.out_valid), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", 64'(p.out_valid), 64'd0);
        chk("arst_a", 64'(p.out_a), 64'd0);
        chk("arst_rd", 64'(p.out_ctl.rd), 64'd0);
        chk("arst_cnt", 64'(cnt), 64'd0);
        chk("arst_cnt4", 64'(cnt4), 64'd0);
        #1;
        rst = 1'b1;

        // saturation on the 4-bit counter
        p.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 14) chk("sat_cnt4_15", 64'(cnt4), 64'd15);
        end
        chk("sat_cnt4", 64'(cnt4), 64'd15);
        chk("sat_cnt", 64'(cnt), 64'd20);
        chk("sat_valid", 64'(p.out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/stage_id_pipe.md
Name: stage_id_pipe

Overview:
- Registered, parametrised successor of the combinational decode stage.
- Decodes one instruction per cycle and selects operands:
  - src A: rs1 or pc
  - src B: rs2 or immediate
- Forwards results from a configurable number of later stages and detects load-use hazards.
- Presents the decoded bundle to EX through a one-entry valid/ready pipeline register, with flush and a stall counter.
- Sits between IF (upstream handshake) and EX (downstream handshake); drives register-file read addresses combinationally.

Parameters:
- Width, 32, data/pc width in bits.
- NumBypass, 2, number of forwarding sources; index 0 = youngest, highest priority.
- CntWidth, 16, width of saturating stall counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  IF presents an instruction.
- in_ready  out  1  ID accepts this cycle.
- in_pc  in  Width  pc of instruction.
- in_opcode  in  32  raw instruction word.
- rs1  out  5  regfile read address, opcode[19:15], combinational.
- rs2  out  5  regfile read address, opcode[24:20], combinational.
- rs1_data  in  Width  regfile read data for rs1, same cycle.
- rs2_data  in  Width  regfile read data for rs2, same cycle.
- byp_valid  in  NumBypass  forwarding source i carries a result.
- byp_rd  in  NumBypass*5  destination register per source.
- byp_data  in  NumBypass*Width  result per source.
- ld_pending  in  1  load in EX whose data is not yet available.
- ld_rd  in  5  destination of that load.
- flush  in  1  squash: branch/jump redirect.
- out_valid  out  1  registered bundle valid.
- out_ready  in  1  EX accepts bundle.
- out_a  out  Width  operand A.
- out_b  out  Width  operand B.
- out_ctl  out  rvcpu::id_ctl_t  rd, rd_valid, aluop, vld_decode, is_branch, is_jal, is_wfi, pc.
- stall_cnt  out  CntWidth  cycles lost to load-use stalls.

Behaviour:
- Reset (rst=0, async):
  - out_valid=0; out_a, out_b, out_ctl all zero; stall_cnt=0.
  - Outputs stay at these values until the first capturing clock edge after rst=1.
- Decode is combinational from in_opcode:
  - decoder supplies rs1_valid, rs2_valid, rd_valid, aluop, immtype and flags.
  - gen_imm supplies the immediate.
- Forwarding, per source operand (rs1, rs2):
  - If reg==0, use regfile data; x0 is never forwarded.
  - Otherwise, the lowest index i with byp_valid[i] && byp_rd[i]==reg wins.
  - If no source matches, use regfile data.
- Operand select:
  - out_a = rs1_valid ? fwd_rs1 : in_pc.
  - out_b = rs2_valid ? fwd_rs2 : imm.
- hazard = in_valid && ld_pending && ld_rd!=0 && ((rs1_valid && rs1==ld_rd) || (rs2_valid && rs2==ld_rd)).
- in_ready:
  - If flush: in_ready=1; the presented instruction is dropped.
  - Else: in_ready = !hazard && (!out_valid || out_ready).
- Register update at each edge, in priority order:
  - flush: out_valid<=0, no capture.
  - else in_valid && in_ready: capture the bundle, out_valid<=1.
  - else out_ready: out_valid<=0.
  - else hold all outputs unchanged.
- Latency: one cycle from acceptance to out_valid.
  - Sustained throughput is one instruction per cycle while out_ready=1 and no hazard.
- Bundle stability: while out_valid && !out_ready, out_a, out_b and out_ctl do not change.
  - Forwarding is sampled at capture only; a held bundle is not refreshed.
- Stall counter:
  - Increments when hazard && !flush.
  - Saturates at all-ones; no wrap.
- Simultaneous events:
  - flush in the same cycle as hazard: the flush wins, the counter does not increment.
  - flush in the same cycle as out_ready: out_valid<=0.
- Reset asserted mid-stall: all state clears immediately; the stalled instruction is lost and IF must re-present it.

Decomposition:
- rvcpu package:
  - id_ctl_t struct.
  - aluop_t.
  - immtype_t (4-bit).
  - reg_t.
  - constant REG_ZERO = 5'd0.
- Sub-module id_bypass:
  - Parametrised by Width and NumBypass.
  - Inputs: one register address, regfile data, and the bypass vectors.
  - Output: the forwarded value.
  - Instantiated twice, once for rs1 and once for rs2.
- decoder, gen_imm and mux are reused unchanged.

Test Plan:
- Reset and basic decode:
  - Hold rst=0, then release.
  - Present addi x5,x1,7 (0x00708293), pc=0x100, rs1_data=10, no bypass.
  - Expect next cycle: out_valid=1, out_a=10, out_b=7, rd=5.
- Forward priority:
  - add x3,x1,x2 with byp0 (rd=1, data=0xAA) and byp1 (rd=1, data=0xBB), rs2_data=4.
  - Expect out_a=0xAA, out_b=4.
  - Repeat with rd=0 in both bypass sources: expect regfile data used.
- Load-use stall:
  - ld_pending=1, ld_rd=2, in_valid with add x3,x1,x2 for 3 cycles.
  - Expect in_ready=0, out_valid stays 0, stall_cnt=3.
  - Drop ld_pending: captured next edge.
- Backpressure:
  - out_ready=0 for 4 cycles after a capture.
  - Expect in_ready=0 and out_a/out_b/out_ctl stable all 4 cycles.
  - Raise out_ready with a new instruction presented: back-to-back transfer, out_valid stays 1.
- Flush:
  - flush=1 coincident with in_valid and a hazard.
  - Expect in_ready=1, out_valid=0 next cycle, stall_cnt unchanged.
- Async reset and saturation:
  - Assert rst between clock edges mid-stall: outputs zero immediately.
  - With CntWidth=4, hold a hazard for 20 cycles: stall_cnt=15.
